// File: rtl/pkg_cpu.sv
// Shared CPU definitions: datapath widths and architecturally named register indices.
package pkg_cpu;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_AT   = 5'd1;
   localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

   function automatic logic is_reg_zero(input logic [ADDR_W-1:0] idx);
      return idx == REG_ZERO;
   endfunction

endpackage

// File: rtl/mod_wr_decoder.sv
// One-hot decoder with enable; output bit 0 is held low so register $zero can never be selected.
module mod_wr_decoder #(
   parameter int ADDR_W = pkg_cpu::ADDR_W
) (
   input  logic                 en,
   input  logic [ADDR_W-1:0]    addr,
   output logic [2**ADDR_W-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
      onehot[0] = 1'b0;
   end

endmodule

// File: rtl/mod_reg_file.sv
// 2R1W general-purpose register file with same-cycle write-through bypass and a
// committed-state debug read port. No handshakes: every port is valid every cycle.
module mod_reg_file
   import pkg_cpu::*;
#(
   parameter int DATA_W = pkg_cpu::DATA_W,
   parameter int ADDR_W = pkg_cpu::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_1,
   input  logic [ADDR_W-1:0] raddr_2,
   output logic [DATA_W-1:0] rdata_1,
   output logic [DATA_W-1:0] rdata_2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int DEPTH = 2**ADDR_W;

   // Register 0 has no storage; the array starts at index 1.
   logic [DATA_W-1:0] regs [1:DEPTH-1];
   logic [DEPTH-1:0]  wr_en;

   mod_wr_decoder #(.ADDR_W(ADDR_W)) u_wr_decoder (
      .en     (we),
      .addr   (waddr),
      .onehot (wr_en)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (wr_en[i]) regs[i] <= wdata;
         end
      end
   end

   // Bypass compare runs beside the array read and picks at the last 2:1 stage.
   always_comb begin
      rdata_1 = '0;
      if (!rst && !is_reg_zero(raddr_1)) begin
         if (we && (waddr == raddr_1)) rdata_1 = wdata;
         else                          rdata_1 = regs[raddr_1];
      end
   end

   always_comb begin
      rdata_2 = '0;
      if (!rst && !is_reg_zero(raddr_2)) begin
         if (we && (waddr == raddr_2)) rdata_2 = wdata;
         else                          rdata_2 = regs[raddr_2];
      end
   end

   // Debug port shows committed state only, never in-flight write data.
   always_comb begin
      dbg_data = '0;
      if (!rst && !is_reg_zero(dbg_addr)) dbg_data = regs[dbg_addr];
   end

endmodule

// File: tb/tb_mod_reg_file.sv
// Self-checking bench for mod_reg_file: vector table, corner-case sequences and a
// reference model feeding an expected-value queue.
module tb_mod_reg_file;
   import pkg_cpu::*;

   logic              clk;
   logic              rst;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr_1;
   logic [ADDR_W-1:0] raddr_2;
   logic [DATA_W-1:0] rdata_1;
   logic [DATA_W-1:0] rdata_2;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;

   mod_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr_1  (raddr_1),
      .raddr_2  (raddr_2),
      .rdata_1  (rdata_1),
      .rdata_2  (rdata_2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) assert (!$isunknown(we));
   end

   // scoreboard
   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] model [0:31];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic push_exp(input logic [DATA_W-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input string name, input logic [DATA_W-1:0] act);
      logic [DATA_W-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: got %h but expected queue is empty", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, e);
         end
      end
   endtask

   // reference for a combinational read port (bypass included)
   function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
      if (rst || a == 0) return '0;
      if (we && waddr == a) return wdata;
      return model[a];
   endfunction

   function automatic logic [DATA_W-1:0] ref_dbg(input logic [ADDR_W-1:0] a);
      if (rst || a == 0) return '0;
      return model[a];
   endfunction

   // drivers
   task automatic check_ports(input string tag);
      push_exp(ref_read(raddr_1));
      push_exp(ref_read(raddr_2));
      push_exp(ref_dbg(dbg_addr));
      pop_check({tag, ".rdata_1"}, rdata_1);
      pop_check({tag, ".rdata_2"}, rdata_2);
      pop_check({tag, ".dbg_data"}, dbg_data);
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      we = 1'b1; waddr = a; wdata = d;
      @(posedge clk);
      if (!rst && a != 0) model[a] = d;
      #1;
      we = 1'b0;
   endtask

   // vector table: inputs plus constant expected outputs sampled before the edge
   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] ra1;
      logic [ADDR_W-1:0] ra2;
      logic [ADDR_W-1:0] da;
      logic [DATA_W-1:0] exp_r1;
      logic [DATA_W-1:0] exp_r2;
      logic [DATA_W-1:0] exp_dbg;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;

      vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd0,  5'd8,  32'hDEADBEEF, 32'h0,        32'h0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd8,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd8,  5'd8,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
      vecs[4]  = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd9,  5'd5,  32'h00000001, 32'h0,        32'h0};
      vecs[5]  = '{1'b1, 5'd5,  32'hCAFE0000, 5'd5,  5'd5,  5'd5,  32'hCAFE0000, 32'hCAFE0000, 32'h00000001};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd8,  5'd5,  32'hCAFE0000, 32'hDEADBEEF, 32'hCAFE0000};
      vecs[7]  = '{1'b0, 5'd8,  32'h11111111, 5'd8,  5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[8]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5,  5'd31, 32'hA5A5A5A5, 32'hCAFE0000, 32'h0};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};

      for (int i = 0; i < 32; i++) model[i] = '0;
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      raddr_1 = 5'd3; raddr_2 = 5'd17; dbg_addr = 5'd31;

      // reset state
      #1;
      check_ports("reset_init");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // table-driven vectors
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         raddr_1 = vecs[i].ra1; raddr_2 = vecs[i].ra2; dbg_addr = vecs[i].da;
         #4;
         push_exp(vecs[i].exp_r1);
         push_exp(vecs[i].exp_r2);
         push_exp(vecs[i].exp_dbg);
         pop_check($sformatf("vec%0d.rdata_1", i), rdata_1);
         pop_check($sformatf("vec%0d.rdata_2", i), rdata_2);
         pop_check($sformatf("vec%0d.dbg_data", i), dbg_data);
         @(posedge clk);
         if (vecs[i].we && vecs[i].waddr != 0) model[vecs[i].waddr] = vecs[i].wdata;
         #1;
      end
      we = 1'b0;

      // sweep: fill 1..31, then read every register through both ports and debug
      for (int i = 1; i < 32; i++) do_write(5'(i), 32'h01010101 * 32'(i));
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         raddr_1 = 5'(i); raddr_2 = 5'(31 - i); dbg_addr = 5'(i);
         #1;
         check_ports($sformatf("sweep%0d", i));
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         raddr_1 = 5'($urandom_range(0, 31)); raddr_2 = 5'($urandom_range(0, 31));
         dbg_addr = 5'($urandom_range(0, 31));
         we = 1'($urandom_range(0, 1)); waddr = 5'($urandom_range(0, 31));
         wdata = $urandom;
         #1;
         check_ports($sformatf("rand%0d", i));
         @(posedge clk);
         if (we && waddr != 0) model[waddr] = wdata;
         #1;
         we = 1'b0;
      end

      // asynchronous reset with random contents, no clock edge in between
      for (int i = 0; i < 8; i++) do_write(5'($urandom_range(1, 31)), $urandom);
      @(negedge clk);
      we = 1'b1; waddr = 5'd12; wdata = 32'h5A5A5A5A;
      raddr_1 = 5'd12; raddr_2 = 5'd31; dbg_addr = 5'd1;
      #1;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) model[i] = '0;
      check_ports("async_rst");
      for (int i = 1; i < 4; i++) begin
         raddr_1 = 5'(i * 7); raddr_2 = 5'(i * 9); dbg_addr = 5'(i * 10);
         #0.5;
         check_ports($sformatf("async_rst_rd%0d", i));
      end

      // write coinciding with an edge while rst is high is lost
      waddr = 5'd7; wdata = 32'h77777777; dbg_addr = 5'd7;
      @(posedge clk);
      #1;
      @(negedge clk);
      we = 1'b0; rst = 1'b0;
      #1;
      push_exp('0);
      pop_check("write_during_rst", dbg_data);

      // reset pulse between edges while a write to 31 is pending
      do_write(REG_RA, 32'h00001234);
      @(negedge clk);
      we = 1'b1; waddr = REG_RA; wdata = 32'hFFFFFFFF;
      raddr_1 = REG_RA; raddr_2 = REG_SP; dbg_addr = REG_RA;
      #1; rst = 1'b1;
      #1; rst = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      #1;
      check_ports("mid_write_rst");
      @(posedge clk);
      model[REG_RA] = 32'hFFFFFFFF;
      #1;
      we = 1'b0;
      #1;
      check_ports("after_rst_write");

      // $at written, then reg-0 write leaves it intact
      do_write(REG_AT, 32'h0BADF00D);
      do_write(REG_ZERO, 32'h12345678);
      @(negedge clk);
      raddr_1 = REG_ZERO; raddr_2 = REG_AT; dbg_addr = REG_AT;
      #1;
      check_ports("zero_immunity");

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL exp_q_drain: got %0d leftover entries expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
